// File: rtl/shift_right_ctrl.sv
// ---------------------------------------------------------------------------
// shift_right_ctrl
//
// Operand/control stage in front of a combinational N-bit logical
// shift-right unit. The operand and the shift amount are captured from a
// shared data bus and driven into the shifter. One cycle after a start
// (EXEC), the shifter output is registered. The registered result and its
// flags are then offered downstream through a valid/ready handshake (DONE).
//
// Optional feature macro: SHIFT_CARRY_FLAG_EN
//   defined     -> flag_carry reports the last bit shifted out of the operand
//   not defined -> flag_carry is tied low and no carry logic is built
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   din        : shared data bus (switches)
//   load_a     : strobe, capture din into the operand register
//   load_sh    : strobe, capture din[2:0] into the shift-amount register
//   start      : strobe, launch one shift operation
//   clr        : synchronous clear of operand, amount, result and flags
//   shf_a      : operand to the shifter
//   shf_amt    : shift amount to the shifter
//   shf_out    : combinational result returned by the shifter
//   out_ready  : downstream accepts the result
//   res_valid  : result and flags are valid
//   result     : registered shift result
//   flag_zero  : result is all zeros
//   flag_carry : last bit shifted out
//   busy       : high while in EXEC or DONE
// ---------------------------------------------------------------------------
module shift_right_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] din,
    input  logic         load_a,
    input  logic         load_sh,
    input  logic         start,
    input  logic         clr,
    output logic [N-1:0] shf_a,
    output logic [2:0]   shf_amt,
    input  logic [N-1:0] shf_out,
    input  logic         out_ready,
    output logic         res_valid,
    output logic [N-1:0] result,
    output logic         flag_zero,
    output logic         flag_carry,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    logic   carry_next;

`ifdef SHIFT_CARRY_FLAG_EN
    // The last bit shifted out is shf_a[shf_amt-1]. The amount is widened to
    // 4 bits so that amount 0 and amounts above N never match any bit and the
    // flag falls back to 0.
    always_comb begin
        carry_next = 1'b0;
        for (int i = 0; i < N; i++) begin
            if ({1'b0, shf_amt} == 4'(i + 1)) begin
                carry_next = shf_a[i];
            end
        end
    end
`else
    assign carry_next = 1'b0;
`endif

    // Single control FSM. All outputs are registered here. clr outranks
    // every strobe. In IDLE, a start that arrives together with a load is
    // dropped so that the load always lands first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shf_a      <= '0;
            shf_amt    <= '0;
            result     <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            res_valid  <= 1'b0;
            busy       <= 1'b0;
        end else if (clr) begin
            state      <= IDLE;
            shf_a      <= '0;
            shf_amt    <= '0;
            result     <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            res_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_a) begin
                        shf_a <= din;
                    end
                    if (load_sh) begin
                        shf_amt <= din[2:0];
                    end
                    if (start && !load_a && !load_sh) begin
                        state <= EXEC;
                        busy  <= 1'b1;
                    end
                end
                EXEC: begin
                    result     <= shf_out;
                    flag_zero  <= (shf_out == '0);
                    flag_carry <= carry_next;
                    res_valid  <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_right_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_right_ctrl
//
// Self-checking bench for shift_right_ctrl with N=4. A behavioural logical
// shifter closes the loop between shf_a/shf_amt and shf_out. Expected results
// come from a constant vector table. They are pushed to a scoreboard queue
// when start is driven and popped when res_valid appears. Hand-written
// sequences cover backpressure, start+load collision, reset and clr.
// ---------------------------------------------------------------------------
module tb_shift_right_ctrl;

    localparam int N = 4;

`ifdef SHIFT_CARRY_FLAG_EN
    localparam logic CarryOn = 1'b1;
`else
    localparam logic CarryOn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] din = '0;
    logic         load_a = 1'b0;
    logic         load_sh = 1'b0;
    logic         start = 1'b0;
    logic         clr = 1'b0;
    logic [N-1:0] shf_a;
    logic [2:0]   shf_amt;
    logic [N-1:0] shf_out;
    logic         out_ready = 1'b1;
    logic         res_valid;
    logic [N-1:0] result;
    logic         flag_zero;
    logic         flag_carry;
    logic         busy;

    typedef struct {
        logic [N-1:0] a;
        logic [2:0]   sh;
        logic [N-1:0] res;
        logic         zero;
        logic         carry;
    } vec_t;

    typedef struct {
        logic [N-1:0] res;
        logic         zero;
        logic         carry;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    // Stand-in for the downstream combinational shifter
    assign shf_out = shf_a >> shf_amt;

    shift_right_ctrl #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .load_a     (load_a),
        .load_sh    (load_sh),
        .start      (start),
        .clr        (clr),
        .shf_a      (shf_a),
        .shf_amt    (shf_amt),
        .shf_out    (shf_out),
        .out_ready  (out_ready),
        .res_valid  (res_valid),
        .result     (result),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .busy       (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_res_valid"}, 32'(res_valid), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_result"}, 32'(result), 0);
        checkOutput({tag, "_shf_a"}, 32'(shf_a), 0);
        checkOutput({tag, "_shf_amt"}, 32'(shf_amt), 0);
        checkOutput({tag, "_flag_zero"}, 32'(flag_zero), 0);
        checkOutput({tag, "_flag_carry"}, 32'(flag_carry), 0);
    endtask

    // Load operand, then amount, then pulse start and queue the expectation.
    // Returns one cycle after start, with the DUT expected to be in EXEC.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        din    = v.a;
        load_a = 1'b1;
        tick();
        load_a  = 1'b0;
        din     = {{(N-3){1'b0}}, v.sh};
        load_sh = 1'b1;
        tick();
        load_sh = 1'b0;
        checkOutput("load_shf_a", 32'(shf_a), 32'(v.a));
        checkOutput("load_shf_amt", 32'(shf_amt), 32'(v.sh));
        e.res   = v.res;
        e.zero  = v.zero;
        e.carry = v.carry & CarryOn;
        start   = 1'b1;
        sb.push_back(e);
        tick();
        start = 1'b0;
        checkOutput("exec_busy", 32'(busy), 1);
        checkOutput("exec_no_valid", 32'(res_valid), 0);
    endtask

    // Wait (bounded) for res_valid, compare against the scoreboard head and,
    // if out_ready is high, confirm the return to IDLE on the next cycle.
    task automatic collectResult(input int expLat);
        exp_t e;
        int   lat = 0;
        while (!res_valid && lat < 8) begin
            tick();
            lat++;
        end
        checkOutput("valid_latency", 32'(lat), 32'(expLat));
        if (!res_valid) begin
            return;
        end
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        checkOutput("result", 32'(result), 32'(e.res));
        checkOutput("flag_zero", 32'(flag_zero), 32'(e.zero));
        checkOutput("flag_carry", 32'(flag_carry), 32'(e.carry));
        if (out_ready) begin
            tick();
            checkOutput("handshake_valid_drop", 32'(res_valid), 0);
            checkOutput("handshake_busy_drop", 32'(busy), 0);
        end
    endtask

    initial begin
        vec_t v;
        // a, sh, result, zero, carry-when-enabled
        vecs[0] = '{4'b1011, 3'd1, 4'b0101, 1'b0, 1'b1};
        vecs[1] = '{4'b1011, 3'd4, 4'b0000, 1'b1, 1'b1};
        vecs[2] = '{4'b1011, 3'd7, 4'b0000, 1'b1, 1'b0};
        vecs[3] = '{4'b1011, 3'd0, 4'b1011, 1'b0, 1'b0};
        vecs[4] = '{4'b1000, 3'd3, 4'b0001, 1'b0, 1'b0};
        vecs[5] = '{4'b0110, 3'd2, 4'b0001, 1'b0, 1'b1};
        vecs[6] = '{4'b0001, 3'd1, 4'b0000, 1'b1, 1'b1};
        vecs[7] = '{4'b1111, 3'd3, 4'b0001, 1'b0, 1'b1};
        vecs[8] = '{4'b0100, 3'd5, 4'b0000, 1'b1, 1'b0};

        $display("[TB] reset state");
        #2;
        checkAllZero("reset");
        #10;
        rst_n = 1'b1;
        tick();

        $display("[TB] vector table");
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            collectResult(1);
        end

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(vecs[0]);
        collectResult(1);
        for (int i = 0; i < 5; i++) begin
            din    = ~din;
            load_a = i[0];
            start  = ~i[0];
            tick();
            checkOutput("stall_valid", 32'(res_valid), 1);
            checkOutput("stall_result", 32'(result), 32'(4'b0101));
            checkOutput("stall_shf_a", 32'(shf_a), 32'(4'b1011));
            checkOutput("stall_zero", 32'(flag_zero), 0);
            checkOutput("stall_carry", 32'(flag_carry), 32'(CarryOn));
        end
        load_a    = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("release_valid", 32'(res_valid), 0);
        checkOutput("release_busy", 32'(busy), 0);

        $display("[TB] start with load_a");
        v = '{4'b1011, 3'd1, 4'b0101, 1'b0, 1'b1};
        applyStimulus(v);
        collectResult(1);
        din    = 4'b0110;
        load_a = 1'b1;
        start  = 1'b1;
        tick();
        load_a = 1'b0;
        start  = 1'b0;
        checkOutput("collide_shf_a", 32'(shf_a), 32'(4'b0110));
        checkOutput("collide_busy", 32'(busy), 0);
        tick();
        checkOutput("collide_still_idle", 32'(busy), 0);
        start = 1'b1;
        sb.push_back('{4'b0011, 1'b0, 1'b0});
        tick();
        start = 1'b0;
        checkOutput("collide_exec_busy", 32'(busy), 1);
        collectResult(1);

        $display("[TB] reset during EXEC");
        applyStimulus(vecs[7]);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("rst_exec");
        sb.delete();
        #2;
        rst_n = 1'b1;
        tick();
        applyStimulus(vecs[5]);
        collectResult(1);

        $display("[TB] reset during DONE");
        out_ready = 1'b0;
        applyStimulus(vecs[3]);
        tick();
        checkOutput("rst_done_pre_valid", 32'(res_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("rst_done");
        sb.delete();
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        applyStimulus(vecs[0]);
        collectResult(1);

        $display("[TB] clr in DONE");
        out_ready = 1'b0;
        applyStimulus(vecs[7]);
        tick();
        checkOutput("clr_pre_valid", 32'(res_valid), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checkAllZero("clr");
        sb.delete();
        out_ready = 1'b1;
        applyStimulus(vecs[5]);
        collectResult(1);

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
